// File: rtl/intersection_phase_arbiter.sv
// Four-approach intersection phase scheduler: round-robin green phase with
// minimum/maximum green, fixed yellow and all-red clearance intervals.
//
// Ports:
//   clock       - system clock, all state changes on the rising edge
//   clear       - asynchronous active-high reset (home approach 0 green)
//   req[3:0]    - vehicle present on approach k (bit k), level-sensitive
//   sig[7:0]    - signal head for approach k at sig[2k+1:2k]
//                 (2'b00 RED, 2'b01 YELLOW, 2'b10 GREEN)
//   gnt_id[1:0] - approach currently owning the phase
//   phase[1:0]  - 2'b00 GREEN, 2'b01 YELLOW, 2'b10 ALLRED
//   green_start - one-cycle pulse in the first cycle of each new green

module intersection_phase_arbiter #(
    parameter int MIN_GREEN   = 4,
    parameter int MAX_GREEN   = 8,
    parameter int YELLOW_TIME = 3,
    parameter int ALLRED_TIME = 2
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] req,
    output logic [7:0] sig,
    output logic [1:0] gnt_id,
    output logic [1:0] phase,
    output logic       green_start
);

    localparam int MAXP_A = (MIN_GREEN > MAX_GREEN) ? MIN_GREEN : MAX_GREEN;
    localparam int MAXP_B = (YELLOW_TIME > ALLRED_TIME) ? YELLOW_TIME
                                                        : ALLRED_TIME;
    localparam int MAXP   = (MAXP_A > MAXP_B) ? MAXP_A : MAXP_B;
    localparam int CW     = $clog2(MAXP) + 1;

    localparam logic [CW-1:0] C_MIN = CW'(MIN_GREEN - 1);
    localparam logic [CW-1:0] C_MAX = CW'(MAX_GREEN - 1);
    localparam logic [CW-1:0] C_YEL = CW'(YELLOW_TIME - 1);
    localparam logic [CW-1:0] C_AR  = CW'(ALLRED_TIME - 1);

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10
    } phase_t;

    phase_t        r_phase;
    logic [1:0]    r_gnt_id;
    logic [1:0]    r_next_id;
    logic [CW-1:0] r_cnt;
    logic          r_green_start;

    logic [3:0]    w_others;
    logic [7:0]    w_dbl;
    logic [2:0]    w_base;
    logic [3:0]    w_rot;
    logic [1:0]    w_next;
    logic          w_leave;
    logic [1:0]    w_head;

    assign w_others = req & ~(4'b0001 << r_gnt_id);

    // Rotate req so bit 0 is the approach after the owner; bit 3 is the
    // owner itself and is never a successor candidate.
    assign w_dbl  = {req, req};
    assign w_base = {1'b0, r_gnt_id} + 3'd1;
    assign w_rot  = w_dbl[w_base +: 4];

    always_comb begin
        w_next = 2'd0;
        if (w_rot[0]) begin
            w_next = r_gnt_id + 2'd1;
        end else if (w_rot[1]) begin
            w_next = r_gnt_id + 2'd2;
        end else if (w_rot[2]) begin
            w_next = r_gnt_id + 2'd3;
        end
    end

    assign w_leave = (r_cnt >= C_MIN) &&
                     (((|w_others) && !req[r_gnt_id]) ||
                      ((|w_others) && (r_cnt == C_MAX)) ||
                      ((r_gnt_id != 2'd0) && (req == 4'd0)));

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            r_phase       <= PH_GREEN;
            r_gnt_id      <= 2'd0;
            r_next_id     <= 2'd0;
            r_cnt         <= '0;
            r_green_start <= 1'b0;
        end else begin
            r_green_start <= 1'b0;
            unique case (r_phase)
                PH_GREEN: begin
                    if (w_leave) begin
                        r_phase   <= PH_YELLOW;
                        r_cnt     <= '0;
                        r_next_id <= w_next;
                    end else if (r_cnt != C_MAX) begin
                        // Saturate so a resting home green never wraps.
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PH_YELLOW: begin
                    if (r_cnt == C_YEL) begin
                        r_phase <= PH_ALLRED;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PH_ALLRED: begin
                    if (r_cnt == C_AR) begin
                        r_phase       <= PH_GREEN;
                        r_cnt         <= '0;
                        r_gnt_id      <= r_next_id;
                        r_green_start <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_phase <= PH_GREEN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_head = 2'b00;
        unique case (r_phase)
            PH_GREEN:  w_head = 2'b10;
            PH_YELLOW: w_head = 2'b01;
            default:   w_head = 2'b00;
        endcase
    end

    // Moore decode: only the owner can be non-red.
    always_comb begin
        sig = 8'h00;
        for (int k = 0; k < 4; k++) begin
            if (r_gnt_id == 2'(k)) begin
                sig[2*k +: 2] = w_head;
            end
        end
    end

    assign gnt_id      = r_gnt_id;
    assign phase       = r_phase;
    assign green_start = r_green_start;

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Self-checking bench for intersection_phase_arbiter: behavioural model
// compared every cycle, directed scenarios, then randomized requests.

module tb_intersection_phase_arbiter;

    localparam int MIN_G = 4;
    localparam int MAX_G = 8;
    localparam int YEL   = 3;
    localparam int AR    = 2;

    logic       clock = 1'b0;
    logic       clear = 1'b1;
    logic [3:0] req   = 4'd0;
    logic [7:0] sig;
    logic [1:0] gnt_id;
    logic [1:0] phase;
    logic       green_start;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    intersection_phase_arbiter #(
        .MIN_GREEN  (MIN_G),
        .MAX_GREEN  (MAX_G),
        .YELLOW_TIME(YEL),
        .ALLRED_TIME(AR)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .req        (req),
        .sig        (sig),
        .gnt_id     (gnt_id),
        .phase      (phase),
        .green_start(green_start)
    );

    always #5 clock = ~clock;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: owner, stage (0 green, 1 yellow, 2 all-red), cycles spent in
    // the stage (unbounded), committed successor and the start pulse.
    int   m_owner, m_stage, m_age, m_next;
    logic m_gs;

    function automatic int rr_pick(logic [3:0] r, int own);
        for (int k = 1; k < 4; k++)
            if (r[(own + k) % 4]) return (own + k) % 4;
        return 0;
    endfunction

    function automatic bit leave(logic [3:0] r, int own, int age);
        logic [3:0] oth;
        oth = r;
        oth[own] = 1'b0;
        if (age < MIN_G - 1) return 1'b0;
        if (oth != 0 && (!r[own] || age >= MAX_G - 1)) return 1'b1;
        return (own != 0 && r == 0);
    endfunction

    function automatic logic [7:0] head(int own, int st);
        logic [7:0] s;
        s = 8'h00;
        s[2*own +: 2] = (st == 0) ? 2'b10 : (st == 1) ? 2'b01 : 2'b00;
        return s;
    endfunction

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            m_owner <= 0;
            m_stage <= 0;
            m_age   <= 0;
            m_next  <= 0;
            m_gs    <= 1'b0;
        end else begin
            m_gs <= 1'b0;
            case (m_stage)
                0: begin
                    if (leave(req, m_owner, m_age)) begin
                        m_stage <= 1;
                        m_age   <= 0;
                        m_next  <= rr_pick(req, m_owner);
                    end else begin
                        m_age <= m_age + 1;
                    end
                end
                1: begin
                    if (m_age + 1 >= YEL) begin
                        m_stage <= 2;
                        m_age   <= 0;
                    end else begin
                        m_age <= m_age + 1;
                    end
                end
                default: begin
                    if (m_age + 1 >= AR) begin
                        m_stage <= 0;
                        m_age   <= 0;
                        m_owner <= m_next;
                        m_gs    <= 1'b1;
                    end else begin
                        m_age <= m_age + 1;
                    end
                end
            endcase
        end
    end

    always @(negedge clock) begin
        if (cmp_en && !clear) begin
            check("cyc_sig", 32'(sig), 32'(head(m_owner, m_stage)));
            check("cyc_phase", 32'(phase), 32'(m_stage));
            check("cyc_gnt", 32'(gnt_id), 32'(m_owner));
            check("cyc_gs", 32'(green_start), 32'(m_gs));
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset(logic [3:0] r);
        clear = 1'b1;
        req   = r;
        @(negedge clock);
        #2;
        clear = 1'b0;
    endtask

    task automatic wait_gs(int lim, string nm);
        for (int i = 0; i < lim; i++) begin
            step();
            if (green_start === 1'b1) return;
        end
        checks++;
        failures++;
        $display("FAIL %s timeout actual=no_green_start required=pulse", nm);
    endtask

    logic [7:0] t2_exp [10] = '{8'h02, 8'h02, 8'h02, 8'h01, 8'h01,
                                8'h01, 8'h00, 8'h00, 8'h20, 8'h20};

    int n;
    int bad;
    int gs_cnt;

    initial begin
        #1;
        check("rst_sig", 32'(sig), 32'h02);
        check("rst_phase", 32'(phase), 32'h0);
        check("rst_gnt", 32'(gnt_id), 32'h0);
        check("rst_gs", 32'(green_start), 32'h0);
        cmp_en = 1'b1;

        // Idle: home rests green.
        do_reset(4'd0);
        bad = 0;
        gs_cnt = 0;
        repeat (30) begin
            step();
            if (sig !== 8'h02 || phase !== 2'b00 || gnt_id !== 2'd0) bad++;
            if (green_start === 1'b1) gs_cnt++;
        end
        check("idle_hold", 32'(bad), 32'd0);
        check("idle_no_gs", 32'(gs_cnt), 32'd0);

        // Single request on approach 2 from cycle 0.
        do_reset(4'b0100);
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("seq2_sig%0d", i), 32'(sig), 32'(t2_exp[i]));
            check($sformatf("seq2_gs%0d", i), 32'(green_start),
                  32'(i == 8));
        end
        check("seq2_gnt", 32'(gnt_id), 32'd2);

        // Approach 1 under contention: green capped at MAX_GREEN.
        do_reset(4'b0010);
        wait_gs(20, "max_gs1");
        req = 4'b0110;
        check("max_first", 32'(sig), 32'h08);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sig == 8'h08) n++;
            else break;
        end
        check("max_len", 32'(n), 32'(MAX_G));
        check("max_yel", 32'(sig), 32'h04);
        wait_gs(20, "max_gs2");
        check("max_next", 32'(gnt_id), 32'd2);
        check("max_sig2", 32'(sig), 32'h20);

        // Round-robin wrap from approach 3, then 0 -> 1.
        do_reset(4'b1000);
        wait_gs(20, "rr_gs3");
        check("rr_own3", 32'(gnt_id), 32'd3);
        req = 4'b1011;
        step();
        step();
        req = 4'b0011;
        wait_gs(30, "rr_gs0");
        check("rr_next0", 32'(gnt_id), 32'd0);
        req = 4'b0010;
        wait_gs(30, "rr_gs1");
        check("rr_next1", 32'(gnt_id), 32'd1);

        // One-cycle pulse on approach 2 at cnt = MIN_GREEN-1.
        do_reset(4'd0);
        step();
        step();
        step();
        req = 4'b0100;
        step();
        req = 4'd0;
        check("pulse_yel_ph", 32'(phase), 32'd1);
        check("pulse_yel_sig", 32'(sig), 32'h01);
        wait_gs(10, "pulse_gs2");
        check("pulse_gnt2", 32'(gnt_id), 32'd2);
        n = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (sig == 8'h20) n++;
            else break;
        end
        check("pulse_len", 32'(n), 32'(MIN_G));
        wait_gs(10, "pulse_home");
        check("pulse_home_gnt", 32'(gnt_id), 32'd0);
        check("pulse_home_sig", 32'(sig), 32'h02);

        // Asynchronous clear in the middle of all-red.
        do_reset(4'b0100);
        n = 0;
        while (phase !== 2'b10 && n < 12) begin
            step();
            n++;
        end
        check("clr_reach_ar", 32'(phase), 32'd2);
        #1;
        clear = 1'b1;
        #1;
        check("clr_sig", 32'(sig), 32'h02);
        check("clr_phase", 32'(phase), 32'd0);
        check("clr_gnt", 32'(gnt_id), 32'd0);
        #14;
        clear = 1'b0;
        wait_gs(15, "clr_restart");
        check("clr_restart_gnt", 32'(gnt_id), 32'd2);

        // Randomized requests with occasional clear pulses.
        do_reset(4'd0);
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c % 500 == 250) begin
                clear = 1'b1;
                #2;
                clear = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                req = 4'($urandom_range(0, 15));
                if ((c / 300) % 2 == 1)
                    req = req & 4'($urandom_range(0, 15));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
